char_ram_arbiter: RTL and testbench

CHAR_RAM_ARBITER -- requirements
Module: char_ram_arbiter

---
 rtl/char_ram_pkg.sv | 20 ++
 rtl/rx_byte_fifo.sv | 54 +++++
 rtl/char_ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_char_ram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_ram_pkg.sv
// Shared definitions for the character RAM arbiter: FSM states,
// default widths and the control characters it interprets.
package char_ram_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_FF    = 8'h0C;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RACK,
    WRITE,
    CLEAR
  } arb_state_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// Small synchronous FIFO buffering received bytes until the arbiter
// gets a free RAM cycle. Head is presented combinationally; a push on
// a full FIFO is accepted only if a pop happens in the same cycle,
// otherwise the byte is dropped and reported on `dropped`.
module rx_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  // One extra pointer bit distinguishes full from empty.
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  // Pointer bookkeeping; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; when full with a simultaneous pop the freed slot is reused.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/char_ram_arbiter.sv
// Arbitrates a single-port character RAM between VGA character fetches
// and text arriving from a UART. VGA reads always win in IDLE; received
// bytes are buffered in a small FIFO and written at a moving cursor.
// Backspace erases the previous cell, form feed blanks the whole screen
// (preemptible by VGA reads) and homes the cursor.
//
// A read is acknowledged with a one-cycle vga_ack while the FSM is back
// in IDLE; a requester that keeps vga_req high through the ack cycle
// gets another, back-to-back read.
module char_ram_arbiter
  import char_ram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEF_DATA_W-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  vga_req,
  input  logic [ADDR_W-1:0]     vga_addr,
  output logic [DEF_DATA_W-1:0] vga_data,
  output logic                  vga_ack,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DEF_DATA_W-1:0] ram_wdata,
  input  logic [DEF_DATA_W-1:0] ram_rdata,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  arb_state_t            state;
  logic [ADDR_W-1:0]     cursor;
  logic [ADDR_W-1:0]     clear_idx;
  logic                  clear_pending;

  logic [DEF_DATA_W-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  fifo_dropped;

  // The FIFO head is consumed only when IDLE has nothing of higher priority.
  assign fifo_pop = (state == IDLE) && !vga_req && !clear_pending && !fifo_empty;
  assign busy     = (state != IDLE) || !fifo_empty;

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DEF_DATA_W)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped)
  );

  // Arbiter FSM with registered RAM and VGA outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cursor        <= '0;
      clear_idx     <= '0;
      clear_pending <= 1'b0;
      overflow      <= 1'b0;
      vga_ack       <= 1'b0;
      vga_data      <= '0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
    end else begin
      vga_ack <= 1'b0;
      ram_we  <= 1'b0;
      if (fifo_dropped) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (vga_req) begin
            state    <= READ;
            ram_addr <= vga_addr;
          end else if (clear_pending) begin
            // Start or resume blanking at the first cell not yet written.
            state     <= CLEAR;
            ram_we    <= 1'b1;
            ram_addr  <= clear_idx;
            ram_wdata <= CHAR_SPACE;
          end else if (!fifo_empty) begin
            if (fifo_head == CHAR_FF) begin
              clear_pending <= 1'b1;
            end else if (fifo_head == CHAR_BS) begin
              // Backspace at home position is swallowed without a write.
              if (cursor != '0) begin
                state     <= WRITE;
                ram_we    <= 1'b1;
                ram_addr  <= cursor - ADDR_ONE;
                ram_wdata <= CHAR_SPACE;
                cursor    <= cursor - ADDR_ONE;
              end
            end else begin
              state     <= WRITE;
              ram_we    <= 1'b1;
              ram_addr  <= cursor;
              ram_wdata <= fifo_head;
              cursor    <= cursor + ADDR_ONE;
            end
          end
        end

        READ: begin
          state <= RACK;
        end

        RACK: begin
          vga_data <= ram_rdata;
          vga_ack  <= 1'b1;
          state    <= IDLE;
        end

        WRITE: begin
          state <= IDLE;
        end

        CLEAR: begin
          // The cell at clear_idx is written during this cycle.
          if (clear_idx == {ADDR_W{1'b1}}) begin
            clear_idx     <= '0;
            clear_pending <= 1'b0;
            cursor        <= '0;
            state         <= IDLE;
          end else begin
            clear_idx <= clear_idx + ADDR_ONE;
            if (vga_req) begin
              state <= IDLE;
            end else begin
              ram_we    <= 1'b1;
              ram_addr  <= clear_idx + ADDR_ONE;
              ram_wdata <= CHAR_SPACE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Directed testbench for char_ram_arbiter with a behavioural one-cycle
// synchronous RAM attached to the RAM port.
module tb_char_ram_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       vga_req;
  logic [7:0] vga_addr;
  logic [7:0] vga_data;
  logic       vga_ack;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       busy;
  logic       overflow;

  logic       ram_wipe;
  logic [7:0] ram_mem [256];
  int         wr_count;
  int         ack_count;

  int checks;
  int errors;

  char_ram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_data  (vga_data),
    .vga_ack   (vga_ack),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM model plus write / ack counters.
  always @(posedge clk) begin
    if (ram_wipe) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      wr_count <= wr_count + 1;
    end
    ram_rdata <= ram_mem[ram_addr];
    if (vga_ack) ack_count <= ack_count + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    $display("send  byte=%02h", b);
  endtask

  // Waits for two consecutive idle cycles (bounded).
  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 2 && n < 3000) begin
      @(negedge clk);
      n++;
      if (!busy) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 2) begin
      errors++;
      $display("FAIL %s: idle timeout, busy=%0b required 0", tag, busy);
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input bit with_byte, input logic [7:0] b,
                         output int lat, output logic [7:0] data,
                         output logic [7:0] addr_seen, output logic we_seen,
                         output int wr_at_ack);
    lat = -1;
    data = 8'h00;
    addr_seen = 8'h00;
    we_seen = 1'b0;
    wr_at_ack = wr_count;
    @(posedge clk); #1;
    vga_addr = addr;
    vga_req  = 1'b1;
    if (with_byte) begin
      rx_data  = b;
      rx_valid = 1'b1;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        addr_seen = ram_addr;
        we_seen   = ram_we;
        rx_valid  = 1'b0;
      end
      if (vga_ack) begin
        lat = k;
        data = vga_data;
        wr_at_ack = wr_count;
        break;
      end
    end
    vga_req  = 1'b0;
    rx_valid = 1'b0;
    $display("read  addr=%02h data=%02h latency=%0d", addr, data, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ram_wipe = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (vga_ack !== 1'b0)   begin errors++; $display("FAIL reset_ack: got %0b required 0", vga_ack); end
    checks++; if (vga_data !== 8'h00) begin errors++; $display("FAIL reset_vga_data: got %02h required 00", vga_data); end
    checks++; if (ram_we !== 1'b0)    begin errors++; $display("FAIL reset_ram_we: got %0b required 0", ram_we); end
    checks++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL reset_ram_addr: got %02h required 00", ram_addr); end
    checks++; if (ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_ram_wdata: got %02h required 00", ram_wdata); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %0b required 0", overflow); end
    @(posedge clk); #1;
    reset = 1'b0;
    ram_wipe = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
  endtask

  task automatic test_write_ab();
    int w0 = wr_count;
    send_byte(8'h41);
    send_byte(8'h42);
    wait_idle("write_ab_idle");
    checks++; if (ram_mem[0] !== 8'h41) begin errors++; $display("FAIL write_ab_ram0: got %02h required 41", ram_mem[0]); end
    checks++; if (ram_mem[1] !== 8'h42) begin errors++; $display("FAIL write_ab_ram1: got %02h required 42", ram_mem[1]); end
    checks++; if (wr_count - w0 != 2) begin errors++; $display("FAIL write_ab_count: got %0d required 2", wr_count - w0); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL write_ab_overflow: got %0b required 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_ab_busy: got %0b required 0", busy); end
  endtask

  task automatic test_read();
    int lat; logic [7:0] data; logic [7:0] a_seen; logic we_seen; int w_ack;
    do_read(8'h01, 1'b0, 8'h00, lat, data, a_seen, we_seen, w_ack);
    checks++; if (lat != 3) begin errors++; $display("FAIL read_latency: got %0d required 3", lat); end
    checks++; if (data !== 8'h42) begin errors++; $display("FAIL read_data: got %02h required 42", data); end
    checks++; if (a_seen !== 8'h01) begin errors++; $display("FAIL read_ram_addr: got %02h required 01", a_seen); end
    checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL read_ram_we: got %0b required 0", we_seen); end
    @(negedge clk);
    checks++; if (vga_ack !== 1'b0) begin errors++; $display("FAIL read_ack_pulse: got %0b required 0", vga_ack); end
  endtask

  task automatic test_same_cycle();
    int lat; logic [7:0] data; logic [7:0] a_seen; logic we_seen; int w_ack;
    int w0 = wr_count;
    do_read(8'h00, 1'b1, 8'h43, lat, data, a_seen, we_seen, w_ack);
    checks++; if (lat != 3) begin errors++; $display("FAIL same_latency: got %0d required 3", lat); end
    checks++; if (data !== 8'h41) begin errors++; $display("FAIL same_data: got %02h required 41", data); end
    checks++; if (w_ack - w0 != 0) begin errors++; $display("FAIL same_write_before_read: got %0d writes required 0", w_ack - w0); end
    wait_idle("same_idle");
    checks++; if (ram_mem[2] !== 8'h43) begin errors++; $display("FAIL same_ram2: got %02h required 43", ram_mem[2]); end
    checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL same_count: got %0d required 1", wr_count - w0); end
  endtask

  task automatic test_wrap();
    int w0;
    for (int i = 3; i < 255; i++) begin
      send_byte(8'h61);
      wait_idle("wrap_fill_idle");
    end
    checks++; if (ram_mem[254] !== 8'h61) begin errors++; $display("FAIL wrap_ram254: got %02h required 61", ram_mem[254]); end
    send_byte(8'h5A);
    wait_idle("wrap_z_idle");
    checks++; if (ram_mem[255] !== 8'h5A) begin errors++; $display("FAIL wrap_ram255: got %02h required 5a", ram_mem[255]); end
    w0 = wr_count;
    send_byte(8'h08);
    wait_idle("wrap_bs0_idle");
    checks++; if (wr_count - w0 != 0) begin errors++; $display("FAIL wrap_bs_at_zero: got %0d writes required 0", wr_count - w0); end
    send_byte(8'h78);
    wait_idle("wrap_x_idle");
    checks++; if (ram_mem[0] !== 8'h78) begin errors++; $display("FAIL wrap_cursor_zero: got %02h at 00 required 78", ram_mem[0]); end
    w0 = wr_count;
    send_byte(8'h08);
    wait_idle("wrap_bs1_idle");
    checks++; if (ram_mem[0] !== 8'h20) begin errors++; $display("FAIL bs_erase: got %02h at 00 required 20", ram_mem[0]); end
    checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL bs_count: got %0d required 1", wr_count - w0); end
  endtask

  task automatic test_clear();
    int lat; logic [7:0] data; logic [7:0] a_seen; logic we_seen; int w_ack;
    int bad = 0;
    int w0 = wr_count;
    send_byte(8'h0C);
    repeat (8) @(posedge clk);
    do_read(8'hFF, 1'b0, 8'h00, lat, data, a_seen, we_seen, w_ack);
    checks++; if (lat != 4) begin errors++; $display("FAIL clear_read_latency: got %0d required 4", lat); end
    checks++; if (data !== 8'h5A) begin errors++; $display("FAIL clear_read_data: got %02h required 5a", data); end
    wait_idle("clear_idle");
    for (int i = 0; i < 256; i++) if (ram_mem[i] !== 8'h20) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_cells: got %0d non-blank cells required 0", bad); end
    checks++; if (wr_count - w0 != 256) begin errors++; $display("FAIL clear_count: got %0d writes required 256", wr_count - w0); end
    send_byte(8'h51);
    wait_idle("clear_q_idle");
    checks++; if (ram_mem[0] !== 8'h51) begin errors++; $display("FAIL clear_cursor_home: got %02h at 00 required 51", ram_mem[0]); end
  endtask

  task automatic test_overflow();
    int w0 = wr_count;
    @(posedge clk); #1;
    vga_addr = 8'h00;
    vga_req  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rx_data  = 8'h31 + 8'(i);
      rx_valid = 1'b1;
      $display("send  byte=%02h (vga held)", rx_data);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b required 1", overflow); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %0b required 1", busy); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (wr_count - w0 != 0) begin errors++; $display("FAIL ovf_starved: got %0d writes required 0", wr_count - w0); end
    @(posedge clk); #1;
    vga_req = 1'b0;
    wait_idle("ovf_idle");
    checks++; if (ram_mem[1] !== 8'h31) begin errors++; $display("FAIL ovf_ram1: got %02h required 31", ram_mem[1]); end
    checks++; if (ram_mem[2] !== 8'h32) begin errors++; $display("FAIL ovf_ram2: got %02h required 32", ram_mem[2]); end
    checks++; if (ram_mem[3] !== 8'h33) begin errors++; $display("FAIL ovf_ram3: got %02h required 33", ram_mem[3]); end
    checks++; if (ram_mem[4] !== 8'h34) begin errors++; $display("FAIL ovf_ram4: got %02h required 34", ram_mem[4]); end
    checks++; if (ram_mem[5] !== 8'h20) begin errors++; $display("FAIL ovf_dropped: got %02h at 05 required 20", ram_mem[5]); end
    checks++; if (wr_count - w0 != 4) begin errors++; $display("FAIL ovf_count: got %0d required 4", wr_count - w0); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b required 1", overflow); end
  endtask

  task automatic test_reset_abort();
    int a0;
    int w0;
    @(posedge clk); #1;
    vga_addr = 8'h01;
    vga_req  = 1'b1;
    @(posedge clk); #1;
    a0 = ack_count;
    w0 = wr_count;
    reset   = 1'b1;
    vga_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL abort_ram_we: got %0b required 0", ram_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b required 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_overflow: got %0b required 0", overflow); end
    repeat (6) @(negedge clk);
    checks++; if (ack_count != a0) begin errors++; $display("FAIL abort_no_ack: got %0d acks required 0", ack_count - a0); end
    checks++; if (ram_mem[1] !== 8'h31 || wr_count != w0) begin errors++; $display("FAIL abort_ram_kept: got %02h at 01 and %0d writes required 31 and 0", ram_mem[1], wr_count - w0); end
    $display("reset during read: acks=%0d", ack_count - a0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    ram_wipe = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    vga_req  = 1'b0;
    vga_addr = 8'h00;

    test_reset();
    test_write_ab();
    test_read();
    test_same_cycle();
    test_wrap();
    test_clear();
    test_overflow();
    test_reset_abort();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
